// File: rtl/common_dffram_pkg.sv
// Sizing helpers shared by every DFF-based RAM variant so depth and
// write-mask width are derived the same way everywhere.
package common_dffram_pkg;

    function automatic int ram_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    function automatic int mask_width(input int data_width, input int grain);
        return data_width / grain;
    endfunction

endpackage

// File: rtl/common_dffram_rdport.sv
// One registered read port: address mux, optional write-forward merge
// (COMMON_DFFRAM_1WNR_BYPASS_EN), output register and valid flag.
module common_dffram_rdport
    import common_dffram_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int MASK_GRAIN = 8
) (
    input  logic                                                 clk,
    input  logic                                                 reset,
`ifdef COMMON_DFFRAM_1WNR_BYPASS_EN
    input  logic                                                 we,
    input  logic [ADDR_WIDTH-1:0]                                waddr,
    input  logic [mask_width(DATA_WIDTH, MASK_GRAIN)-1:0]        wmask,
    input  logic [DATA_WIDTH-1:0]                                din,
`endif
    input  logic [ram_depth(ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]     entries,
    input  logic                                                 re,
    input  logic [ADDR_WIDTH-1:0]                                raddr,
    output logic [DATA_WIDTH-1:0]                                dout,
    output logic                                                 dout_valid
);

    logic [DATA_WIDTH-1:0] rdata;

`ifdef COMMON_DFFRAM_1WNR_BYPASS_EN
    localparam int LANES = mask_width(DATA_WIDTH, MASK_GRAIN);

    // Lanes being written this cycle come from din, the rest from storage.
    always_comb begin
        rdata = entries[raddr];
        if (we && (waddr == raddr)) begin
            for (int k = 0; k < LANES; k++) begin
                if (wmask[k]) rdata[k*MASK_GRAIN +: MASK_GRAIN] = din[k*MASK_GRAIN +: MASK_GRAIN];
            end
        end
    end
`else
    assign rdata = entries[raddr];
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            dout_valid <= re;
            if (re) dout <= rdata;
        end
    end

endmodule

// File: rtl/common_dffram_1wnr.sv
// DFF RAM, one masked write port and RAM_READ_PORTS registered read ports.
// Define COMMON_DFFRAM_1WNR_BYPASS_EN to forward same-cycle writes to reads.
module common_dffram_1wnr
    import common_dffram_pkg::*;
#(
    parameter int RAM_DATA_WIDTH = 8,
    parameter int RAM_ADDR_WIDTH = 2,
    parameter int RAM_READ_PORTS = 2,
    parameter int RAM_MASK_GRAIN = 8,
    parameter logic [ram_depth(RAM_ADDR_WIDTH)*RAM_DATA_WIDTH-1:0] RAM_RESET_VALUE = '0
) (
    input  logic                                                  clk,
    input  logic                                                  reset,
    input  logic                                                  we,
    input  logic [RAM_ADDR_WIDTH-1:0]                             waddr,
    input  logic [mask_width(RAM_DATA_WIDTH, RAM_MASK_GRAIN)-1:0] wmask,
    input  logic [RAM_DATA_WIDTH-1:0]                             din,
    input  logic [RAM_READ_PORTS-1:0]                             re,
    input  logic [RAM_READ_PORTS*RAM_ADDR_WIDTH-1:0]              raddr,
    output logic [RAM_READ_PORTS*RAM_DATA_WIDTH-1:0]              dout,
    output logic [RAM_READ_PORTS-1:0]                             dout_valid
);

    localparam int DEPTH = ram_depth(RAM_ADDR_WIDTH);
    localparam int LANES = mask_width(RAM_DATA_WIDTH, RAM_MASK_GRAIN);

    logic [DEPTH-1:0][LANES-1:0][RAM_MASK_GRAIN-1:0] mem;

    // Each lane of each entry is its own enabled register; an all-zero
    // mask therefore writes nothing.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem <= RAM_RESET_VALUE;
        end else if (we) begin
            for (int k = 0; k < LANES; k++) begin
                if (wmask[k]) mem[waddr][k] <= din[k*RAM_MASK_GRAIN +: RAM_MASK_GRAIN];
            end
        end
    end

    for (genvar p = 0; p < RAM_READ_PORTS; p++) begin : g_rd
        common_dffram_rdport #(
            .DATA_WIDTH (RAM_DATA_WIDTH),
            .ADDR_WIDTH (RAM_ADDR_WIDTH),
            .MASK_GRAIN (RAM_MASK_GRAIN)
        ) u_rd (
            .clk        (clk),
            .reset      (reset),
`ifdef COMMON_DFFRAM_1WNR_BYPASS_EN
            .we         (we),
            .waddr      (waddr),
            .wmask      (wmask),
            .din        (din),
`endif
            .entries    (mem),
            .re         (re[p]),
            .raddr      (raddr[p*RAM_ADDR_WIDTH +: RAM_ADDR_WIDTH]),
            .dout       (dout[p*RAM_DATA_WIDTH +: RAM_DATA_WIDTH]),
            .dout_valid (dout_valid[p])
        );
    end

endmodule

// File: tb/tb_common_dffram_1wnr.sv
// Bench for common_dffram_1wnr: default 8b/2-port instance plus a 16b/4-port
// instance, directed tables and random traffic against an array model.
module tb_common_dffram_1wnr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef COMMON_DFFRAM_1WNR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam logic [31:0] A_RST = 32'h1312_1110;
    localparam logic [63:0] B_RST = 64'h0303_0202_0101_0000;
    localparam logic [7:0]  COLL  = BYP ? 8'hC3 : 8'h55;

    logic        reset;
    logic        a_we;
    logic [1:0]  a_waddr;
    logic [0:0]  a_wmask;
    logic [7:0]  a_din;
    logic [1:0]  a_re;
    logic [3:0]  a_raddr;
    logic [15:0] a_dout;
    logic [1:0]  a_dv;

    logic        b_we;
    logic [1:0]  b_waddr;
    logic [1:0]  b_wmask;
    logic [15:0] b_din;
    logic [3:0]  b_re;
    logic [7:0]  b_raddr;
    logic [63:0] b_dout;
    logic [3:0]  b_dv;

    common_dffram_1wnr #(.RAM_RESET_VALUE(A_RST)) u_a (
        .clk(clk), .reset(reset), .we(a_we), .waddr(a_waddr), .wmask(a_wmask),
        .din(a_din), .re(a_re), .raddr(a_raddr), .dout(a_dout), .dout_valid(a_dv));

    common_dffram_1wnr #(
        .RAM_DATA_WIDTH(16), .RAM_ADDR_WIDTH(2), .RAM_READ_PORTS(4),
        .RAM_MASK_GRAIN(8), .RAM_RESET_VALUE(B_RST)
    ) u_b (
        .clk(clk), .reset(reset), .we(b_we), .waddr(b_waddr), .wmask(b_wmask),
        .din(b_din), .re(b_re), .raddr(b_raddr), .dout(b_dout), .dout_valid(b_dv));

    // Reference model: plain arrays of entries and last-read values.
    logic [7:0]  ma_mem [4];
    logic [7:0]  ma_dout[2];
    logic [1:0]  ma_dv;
    logic [15:0] mb_mem [4];
    logic [15:0] mb_dout[4];
    logic [3:0]  mb_dv;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Value a reader sees: stored entry, with this cycle's write lanes
    // overlaid when forwarding is built in.
    function automatic logic [15:0] seen16(input logic [15:0] stored, input logic hit,
                                          input logic [1:0] mask, input logic [15:0] d);
        logic [15:0] v = stored;
        if (BYP && hit) begin
            if (mask[0]) v[7:0]  = d[7:0];
            if (mask[1]) v[15:8] = d[15:8];
        end
        return v;
    endfunction

    task automatic model_step();
        int ad;
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                ma_mem[i] = A_RST[i*8 +: 8];
                mb_mem[i] = B_RST[i*16 +: 16];
                mb_dout[i] = '0;
            end
            ma_dout[0] = '0; ma_dout[1] = '0;
            ma_dv = '0; mb_dv = '0;
            return;
        end
        for (int p = 0; p < 2; p++) begin
            ma_dv[p] = a_re[p];
            if (a_re[p]) begin
                ad = int'(a_raddr[p*2 +: 2]);
                ma_dout[p] = seen16({8'h00, ma_mem[ad]}, a_we && (int'(a_waddr) == ad),
                                    {1'b0, a_wmask[0]}, {8'h00, a_din}) & 16'h00FF;
            end
        end
        for (int p = 0; p < 4; p++) begin
            mb_dv[p] = b_re[p];
            if (b_re[p]) begin
                ad = int'(b_raddr[p*2 +: 2]);
                mb_dout[p] = seen16(mb_mem[ad], b_we && (int'(b_waddr) == ad), b_wmask, b_din);
            end
        end
        if (a_we && a_wmask[0]) ma_mem[a_waddr] = a_din;
        if (b_we) begin
            if (b_wmask[0]) mb_mem[b_waddr][7:0]  = b_din[7:0];
            if (b_wmask[1]) mb_mem[b_waddr][15:8] = b_din[15:8];
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("a_dout_model", {48'h0, a_dout}, {48'h0, ma_dout[1], ma_dout[0]});
        check("a_dv_model", {62'h0, a_dv}, {62'h0, ma_dv});
        check("b_dout_model", b_dout, {mb_dout[3], mb_dout[2], mb_dout[1], mb_dout[0]});
        check("b_dv_model", {60'h0, b_dv}, {60'h0, mb_dv});
    endtask

    typedef struct {
        logic        rst;
        logic        we;
        logic [1:0]  wa;
        logic        wm;
        logic [7:0]  din;
        logic [1:0]  re;
        logic [3:0]  ra;
        logic [15:0] dout;
        logic [1:0]  dv;
    } vec_t;

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 2'd0, 1'b1, 8'hFF, 2'b11, 4'h0, 16'h0000, 2'b00};
        tbl[1]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 2'b11, 4'b1100, 16'h1310, 2'b11};
        tbl[2]  = '{1'b0, 1'b1, 2'd2, 1'b1, 8'h55, 2'b00, 4'h0, 16'h1310, 2'b00};
        tbl[3]  = '{1'b0, 1'b1, 2'd2, 1'b1, 8'hC3, 2'b01, 4'b0010, {8'h13, COLL}, 2'b01};
        tbl[4]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 2'b01, 4'b0010, 16'h13C3, 2'b01};
        tbl[5]  = '{1'b0, 1'b1, 2'd1, 1'b1, 8'h77, 2'b00, 4'h0, 16'h13C3, 2'b00};
        tbl[6]  = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 2'b10, 4'b0100, 16'h77C3, 2'b10};
        tbl[7]  = '{1'b0, 1'b1, 2'd1, 1'b1, 8'h01, 2'b00, 4'b0100, 16'h77C3, 2'b00};
        tbl[8]  = '{1'b0, 1'b1, 2'd1, 1'b1, 8'h02, 2'b00, 4'b0100, 16'h77C3, 2'b00};
        tbl[9]  = '{1'b0, 1'b1, 2'd1, 1'b1, 8'h03, 2'b00, 4'b0100, 16'h77C3, 2'b00};
        tbl[10] = '{1'b0, 1'b1, 2'd0, 1'b0, 8'hAA, 2'b00, 4'h0, 16'h77C3, 2'b00};
        tbl[11] = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 2'b11, 4'b0100, 16'h0310, 2'b11};
        tbl[12] = '{1'b1, 1'b1, 2'd0, 1'b1, 8'hFF, 2'b11, 4'h0, 16'h0000, 2'b00};
        tbl[13] = '{1'b0, 1'b0, 2'd0, 1'b0, 8'h00, 2'b11, 4'b0100, 16'h1110, 2'b11};

        reset = 1'b1;
        a_we = 1'b0; a_waddr = '0; a_wmask = '0; a_din = '0; a_re = '0; a_raddr = '0;
        b_we = 1'b0; b_waddr = '0; b_wmask = '0; b_din = '0; b_re = '0; b_raddr = '0;

        // Directed table on the 8-bit, 2-port instance.
        for (int i = 0; i < 14; i++) begin
            reset = tbl[i].rst; a_we = tbl[i].we; a_waddr = tbl[i].wa;
            a_wmask = tbl[i].wm; a_din = tbl[i].din; a_re = tbl[i].re; a_raddr = tbl[i].ra;
            cycle();
            check($sformatf("tbl%0d_dout", i), {48'h0, a_dout}, {48'h0, tbl[i].dout});
            check($sformatf("tbl%0d_dv", i), {62'h0, a_dv}, {62'h0, tbl[i].dv});
        end
        a_we = 1'b0; a_re = '0;

        // Masked write on the 16-bit instance, then all ports on one address.
        b_we = 1'b1; b_waddr = 2'd1; b_wmask = 2'b11; b_din = 16'hAAAA; cycle();
        b_wmask = 2'b01; b_din = 16'h1234; cycle();
        b_we = 1'b0; b_re = 4'b1111; b_raddr = 8'b01_01_01_01; cycle();
        check("b_same_addr", b_dout, {4{16'hAA34}});
        check("b_same_dv", {60'h0, b_dv}, 64'hF);

        b_re = '0; b_we = 1'b1; b_wmask = 2'b11;
        b_waddr = 2'd0; b_din = 16'h1111; cycle();
        check("b_idle_dv", {60'h0, b_dv}, 64'h0);
        b_waddr = 2'd2; b_din = 16'h2222; cycle();
        b_waddr = 2'd3; b_din = 16'h3333; cycle();
        b_we = 1'b0; b_re = 4'b1111; b_raddr = 8'b11_10_01_00; cycle();
        check("b_distinct", b_dout, {16'h3333, 16'h2222, 16'hAA34, 16'h1111});
        check("b_distinct_dv", {60'h0, b_dv}, 64'hF);

        // Partial-lane collision: only the upper lane is forwarded.
        b_we = 1'b1; b_waddr = 2'd3; b_wmask = 2'b10; b_din = 16'hABCD;
        b_re = 4'b0001; b_raddr = 8'b00_00_00_11; cycle();
        check("b_coll_lane", {48'h0, b_dout[15:0]}, {48'h0, (BYP ? 16'hAB33 : 16'h3333)});
        b_we = 1'b0; cycle();
        check("b_after_coll", {48'h0, b_dout[15:0]}, 64'hAB33);

        // Random traffic on both instances with occasional reset.
        for (int n = 0; n < 400; n++) begin
            reset   = ($urandom_range(0, 31) == 0);
            a_we    = 1'($urandom);   a_waddr = 2'($urandom); a_wmask = 1'($urandom);
            a_din   = 8'($urandom);   a_re    = 2'($urandom); a_raddr = 4'($urandom);
            b_we    = 1'($urandom);   b_waddr = 2'($urandom); b_wmask = 2'($urandom);
            b_din   = 16'($urandom);  b_re    = 4'($urandom); b_raddr = 8'($urandom);
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
